// File: rtl/ps2_key_event_ctrl_if.sv
// Key-event stream between the PS/2 event controller and its consumer.
// The master side presents the FIFO head; the slave side accepts it with ready.
interface ps2_key_event_ctrl_if;
    logic       o_event_valid;
    logic       i_event_ready;
    logic [7:0] o_event_code;
    logic       o_event_ext;
    logic       o_event_break;

    modport master (
        output o_event_valid, o_event_code, o_event_ext, o_event_break,
        input  i_event_ready
    );

    modport slave (
        input  o_event_valid, o_event_code, o_event_ext, o_event_break,
        output i_event_ready
    );
endinterface

// File: rtl/ps2_key_event_ctrl.sv
// Turns PS/2 scan-code-set-2 bytes (with E0/F0 prefixes) into buffered key events,
// and pulses the receiver reset when a multi-byte sequence stalls.
module ps2_key_event_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int RST_CYC     = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [7:0]           i_byte,
    input  logic                 i_byte_valid,
    input  logic                 i_clr,
    output logic                 o_rcv_rst_n,
    ps2_key_event_ctrl_if.master evt,
    output logic                 o_overflow,
    output logic [7:0]           o_err_cnt
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int TIMER_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int RCNT_W  = $clog2(RST_CYC + 1);

    localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYC - 1);
    localparam logic [RCNT_W-1:0]  RST_LEN   = RCNT_W'(RST_CYC);

    typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } key_event_t;

    state_t             state, state_next;
    logic               byte_valid_q;
    logic               strobe_q;
    logic [7:0]         byte_q;
    logic               strobe;
    logic               timeout;
    logic [TIMER_W-1:0] timer;
    logic [RCNT_W-1:0]  rst_cnt;

    logic               push;
    logic               err_fsm;
    key_event_t         push_event;

    key_event_t         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               full, pop, push_ok;

    // Registered rising-edge detect; the byte is captured on the same edge.
    // NOTE: sequential state uses non-blocking assignments so every register sees
    // the pre-edge value of its neighbours, independent of block ordering.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            byte_valid_q <= 1'b0;
            strobe_q     <= 1'b0;
            byte_q       <= 8'h00;
        end else begin
            byte_valid_q <= i_byte_valid;
            strobe_q     <= i_byte_valid & ~byte_valid_q;
            byte_q       <= i_byte;
        end
    end

    // Bytes arriving while the receiver is held in reset are meaningless.
    assign strobe  = strobe_q & o_rcv_rst_n;
    assign timeout = (state != IDLE) && !strobe && (timer == TIMER_MAX);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        if (timeout) begin
            state_next = IDLE;
        end else if (strobe) begin
            unique case (state)
                IDLE: begin
                    if (byte_q == 8'hE0)      state_next = GOT_E0;
                    else if (byte_q == 8'hF0) state_next = GOT_F0;
                end
                GOT_E0: begin
                    if (byte_q == 8'hF0)      state_next = GOT_E0F0;
                    else if (byte_q != 8'hE0) state_next = IDLE;
                end
                GOT_F0: begin
                    if (byte_q != 8'hF0)      state_next = IDLE;
                end
                GOT_E0F0: state_next = IDLE;
                default:  state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        push       = 1'b0;
        err_fsm    = 1'b0;
        push_event = '{code: byte_q, ext: 1'b0, brk: 1'b0};
        if (strobe && !timeout) begin
            unique case (state)
                IDLE: begin
                    unique case (byte_q)
                        8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'hFE: ;
                        8'h00, 8'hFF: err_fsm = 1'b1;
                        default:      push    = 1'b1;
                    endcase
                end
                GOT_E0: begin
                    push_event.ext = 1'b1;
                    push           = (byte_q != 8'hE0) && (byte_q != 8'hF0);
                end
                GOT_F0: begin
                    push_event.brk = 1'b1;
                    err_fsm        = (byte_q == 8'hE0);
                    push           = (byte_q != 8'hE0) && (byte_q != 8'hF0);
                end
                GOT_E0F0: begin
                    push_event.ext = 1'b1;
                    push_event.brk = 1'b1;
                    err_fsm        = (byte_q == 8'hE0) || (byte_q == 8'hF0);
                    push           = !err_fsm;
                end
                default: ;
            endcase
        end
    end

    // Stall timer and receiver reset pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            timer   <= '0;
            rst_cnt <= '0;
        end else begin
            if (state == IDLE || strobe || timeout) timer <= '0;
            else                                    timer <= timer + TIMER_W'(1);

            if (timeout)                rst_cnt <= RST_LEN;
            else if (rst_cnt != '0)     rst_cnt <= rst_cnt - RCNT_W'(1);
        end
    end

    assign o_rcv_rst_n = (rst_cnt == '0);

    // Event FIFO with show-ahead head.
    assign full    = (count == FULL_CNT);
    assign pop     = evt.o_event_valid & evt.i_event_ready;
    assign push_ok = push & (~full | pop);

    // NOTE: the storage array has no reset; only pointers and occupancy do, and the
    // head outputs are gated by valid so unwritten entries never reach the port.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr] <= push_event;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign evt.o_event_valid = (count != '0);
    assign evt.o_event_code  = evt.o_event_valid ? mem[rd_ptr].code : 8'h00;
    assign evt.o_event_ext   = evt.o_event_valid & mem[rd_ptr].ext;
    assign evt.o_event_break = evt.o_event_valid & mem[rd_ptr].brk;

    // Status: clear takes priority over a same-cycle error or drop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overflow <= 1'b0;
            o_err_cnt  <= 8'h00;
        end else if (i_clr) begin
            o_overflow <= 1'b0;
            o_err_cnt  <= 8'h00;
        end else begin
            if (push && full && !pop) o_overflow <= 1'b1;
            if ((err_fsm || timeout) && o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl: table of byte sequences with expected
// events, plus hand sequences for latency, overflow, timeout and reset corners.
module tb_ps2_key_event_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       clr;
    logic       rcv_rst_n;
    logic       overflow;
    logic [7:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_err  = 0;

    ps2_key_event_ctrl_if evt_if ();

    ps2_key_event_ctrl #(
        .FIFO_DEPTH  (4),
        .TIMEOUT_CYC (200),
        .RST_CYC     (4)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_byte       (byte_in),
        .i_byte_valid (byte_valid),
        .i_clr        (clr),
        .o_rcv_rst_n  (rcv_rst_n),
        .evt          (evt_if.master),
        .o_overflow   (overflow),
        .o_err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:2][7:0] b;
        int              n;
        logic            ev;
        logic [7:0]      code;
        logic            ext;
        logic            brk;
        int              derr;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] b0, b1, b2, input int n, input logic ev,
                                input logic [7:0] code, input logic ext, brk, input int derr);
        vec_t v;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2;
        v.n = n; v.ev = ev; v.code = code; v.ext = ext; v.brk = brk; v.derr = derr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop_one();
        @(negedge clk);
        evt_if.i_event_ready = 1'b1;
        @(negedge clk);
        evt_if.i_event_ready = 1'b0;
    endtask

    task automatic check_head(input string name, input logic [7:0] code, input logic ext, brk);
        check({name, "_valid"}, evt_if.o_event_valid, 1);
        check({name, "_code"},  evt_if.o_event_code,  code);
        check({name, "_ext"},   evt_if.o_event_ext,   ext);
        check({name, "_brk"},   evt_if.o_event_break, brk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("rst_valid",    evt_if.o_event_valid, 0);
        check("rst_code",     evt_if.o_event_code,  0);
        check("rst_ext",      evt_if.o_event_ext,   0);
        check("rst_brk",      evt_if.o_event_break, 0);
        check("rst_overflow", overflow,             0);
        check("rst_err",      err_cnt,              0);
        check("rst_rcv_rst",  rcv_rst_n,            1);
        exp_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    vec_t       vecs [12];
    logic [7:0] codes [6];
    int         low_cycles;

    initial begin
        rst_n = 1'b1; byte_in = 8'h00; byte_valid = 1'b0; clr = 1'b0;
        evt_if.i_event_ready = 1'b0;

        vecs[0]  = mk(8'h1C, 8'h00, 8'h00, 1, 1, 8'h1C, 0, 0, 0);
        vecs[1]  = mk(8'hF0, 8'h1C, 8'h00, 2, 1, 8'h1C, 0, 1, 0);
        vecs[2]  = mk(8'hE0, 8'hF0, 8'h75, 3, 1, 8'h75, 1, 1, 0);
        vecs[3]  = mk(8'hE0, 8'h75, 8'h00, 2, 1, 8'h75, 1, 0, 0);
        vecs[4]  = mk(8'hF0, 8'hE0, 8'h00, 2, 0, 8'h00, 0, 0, 1);
        vecs[5]  = mk(8'hAA, 8'hFA, 8'hFE, 3, 0, 8'h00, 0, 0, 0);
        vecs[6]  = mk(8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 1);
        vecs[7]  = mk(8'hFF, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 1);
        vecs[8]  = mk(8'hE0, 8'hF0, 8'hF0, 3, 0, 8'h00, 0, 0, 1);
        vecs[9]  = mk(8'hE0, 8'hE0, 8'h6B, 3, 1, 8'h6B, 1, 0, 0);
        vecs[10] = mk(8'hF0, 8'hF0, 8'h6B, 3, 1, 8'h6B, 0, 1, 0);
        vecs[11] = mk(8'hE0, 8'hF0, 8'hE0, 3, 0, 8'h00, 0, 0, 1);

        do_reset();

        // Latency: strobe sampled at edge k, head valid visible after edge k+1.
        @(negedge clk);
        byte_in = 8'h1C; byte_valid = 1'b1;
        @(posedge clk); #1;
        check("lat_valid_k", evt_if.o_event_valid, 0);
        @(posedge clk); #1;
        check("lat_valid_k1", evt_if.o_event_valid, 1);
        @(negedge clk);
        byte_valid = 1'b0;
        check_head("lat", 8'h1C, 0, 0);
        pop_one();

        // Table-driven sequences.
        foreach (vecs[i]) begin
            for (int j = 0; j < vecs[i].n; j++) send_byte(vecs[i].b[j]);
            wait_cycles(2);
            exp_err += vecs[i].derr;
            check($sformatf("vec%0d_valid", i), evt_if.o_event_valid, vecs[i].ev);
            if (vecs[i].ev) begin
                check_head($sformatf("vec%0d", i), vecs[i].code, vecs[i].ext, vecs[i].brk);
                pop_one();
            end
            check($sformatf("vec%0d_err", i), err_cnt, exp_err);
        end

        // Overflow: six makes into a 4-deep FIFO, then drain in order.
        codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h35, 8'h3C};
        check("ovf_pre", overflow, 0);
        foreach (codes[i]) send_byte(codes[i]);
        wait_cycles(2);
        check("ovf_set", overflow, 1);
        for (int i = 0; i < 4; i++) begin
            check_head($sformatf("drain%0d", i), codes[i], 0, 0);
            pop_one();
        end
        check("drain_empty", evt_if.o_event_valid, 0);
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        exp_err = 0;
        check("clr_overflow", overflow, 0);
        check("clr_err", err_cnt, 0);

        // Timeout: E0 then silence.
        send_byte(8'hE0);
        for (int i = 0; i < 400 && rcv_rst_n; i++) @(negedge clk);
        check("to_fired", rcv_rst_n, 0);
        low_cycles = 0;
        while (!rcv_rst_n && low_cycles < 20) begin
            low_cycles++;
            @(negedge clk);
        end
        check("to_pulse_len", low_cycles, 4);
        check("to_err", err_cnt, 1);
        exp_err = 1;
        send_byte(8'h1C);
        wait_cycles(2);
        check_head("to_next", 8'h1C, 0, 0);
        pop_one();
        check("to_empty", evt_if.o_event_valid, 0);

        // Full FIFO with push and pop on the same edge.
        foreach (codes[i]) if (i < 4) send_byte(codes[i]);
        wait_cycles(2);
        @(negedge clk);
        byte_in = 8'h44; byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0; evt_if.i_event_ready = 1'b1;
        @(negedge clk);
        evt_if.i_event_ready = 1'b0;
        wait_cycles(2);
        check("pp_overflow", overflow, 0);
        for (int i = 1; i < 4; i++) begin
            check_head($sformatf("pp%0d", i), codes[i], 0, 0);
            pop_one();
        end
        check_head("pp_new", 8'h44, 0, 0);
        pop_one();
        check("pp_empty", evt_if.o_event_valid, 0);

        // Error counter saturation.
        for (int i = 0; i < 258; i++) send_byte(8'h00);
        wait_cycles(2);
        check("err_sat", err_cnt, 255);

        // Reset in the middle of E0 F0 with events queued.
        send_byte(8'h16);
        send_byte(8'hE0);
        send_byte(8'hF0);
        do_reset();
        check("post_rst_empty", evt_if.o_event_valid, 0);
        send_byte(8'h1E);
        wait_cycles(2);
        check_head("post_rst", 8'h1E, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
